txhex_word: RTL and testbench
=============================

Name: txhex_word

Overview:
Parametrised hex-word serialiser, successor to the fixed 32-bit hex transmitter.
- Accepts one DW-bit word per request.
- Emits its ASCII hex text, MSB nibble first, as a byte stream to the UART transmitter through a strobe/busy handshake.
- Optional "0x" prefix, selectable case and selectable line terminator.
- Sits between debug/status producers and the serial-port byte sink (txuart).

Parameters:
DW, 32, data width in bits; multiple of 4, range 4..64; any other value is an elaboration error
PREFIX, 1, 1 = emit "0x" before the digits; 0 = no prefix
UPPERCASE, 0, 1 = digits a-f sent as 0x41..0x46; 0 = sent as 0x61..0x66
EOL, 2, 0 = no terminator; 1 = "\n"; 2 = "\r\n"

Ports:
i_clk  input  1  clock, rising edge
i_reset_n  input  1  asynchronous active-low reset
i_stb  input  1  request: transmit i_data
i_data  input  DW  word to print
o_busy  output  1  high while a word is in progress; i_stb is ignored while high
o_done  output  1  one-cycle pulse on the cycle after the final byte is accepted
o_tx_stb  output  1  byte valid toward the byte sink
o_tx_data  output  8  ASCII byte toward the byte sink
i_tx_busy  input  1  byte sink busy; a byte is accepted on any cycle with o_tx_stb && !i_tx_busy

Behaviour:
- Reset is asynchronous and active-low. While i_reset_n=0 all of the following hold immediately: o_busy=0, o_done=0, o_tx_stb=0, o_tx_data=8'h00, state=IDLE, shift register cleared.
- Reset asserted mid-word aborts the word. No further bytes are presented, and no o_done pulse is produced.
- Request: i_stb && !o_busy at cycle N captures i_data into the shift register.
  - At N+1: o_busy=1, o_tx_stb=1, o_tx_data holds the first character.
  - i_stb while o_busy=1 is dropped. The capture register does not change.
- Byte handshake:
  - o_tx_stb and o_tx_data stay stable until accepted.
  - On acceptance at cycle K, the next character is presented at K+1 with o_tx_stb held high. The strobe has no idle gap between bytes.
- State machine: IDLE -> PFX0 ('0') -> PFX1 ('x') -> DIGIT -> CR ("\r") -> LF ("\n") -> IDLE.
  - PFX0 and PFX1 are skipped when PREFIX=0.
  - CR is skipped when EOL<2. CR and LF are both skipped when EOL=0.
  - A state advances only on byte acceptance.
- DIGIT:
  - A nibble counter runs from NIB=DW/4 down to 1. On each accepted digit the shift register shifts left by 4.
  - Character mapping: n<10 -> 8'h30+n. n>=10 -> 8'h61+(n-10), or 8'h41+(n-10) when UPPERCASE=1.
- Completion:
  - Final byte accepted at cycle M -> at M+1: o_busy=0, o_tx_stb=0, o_done=1 for exactly one cycle.
  - A new i_stb at M+1 is accepted, and its first byte is presented at M+2. Back-to-back words therefore have a one-cycle strobe gap.
- Byte counts: bytes per word = 2*PREFIX + NIB + EOL. The default configuration sends 12 bytes.
- i_tx_busy held high indefinitely stalls the block with the current byte held stable; this is not an error.
- o_tx_data holds its last value when idle (not re-zeroed).

Optional Feature:
Macro TXHEX_ZERO_SUPPRESS_EN.
- Defined:
  - Leading zero nibbles are skipped within the DIGIT state.
  - Skipping costs no bus cycles: the first non-zero nibble is located when the word is captured.
  - The least significant digit is always sent, so value 0 prints "0".
  - Prefix and terminator are unaffected.
  - Bytes per word = 2*PREFIX + max(1, NIB - leading_zero_nibbles) + EOL.
- Undefined: all NIB digits are always sent, and the zero-detection logic is absent from the netlist.

Test Plan:
- Defaults, i_tx_busy tied 0, i_stb with 32'h12345678 -> bytes "0x12345678\r\n" (30 78 31 32 33 34 35 36 37 38 0D 0A) on 12 consecutive cycles; o_done pulse 1 cycle after the 0A acceptance.
- DW=16, PREFIX=0, UPPERCASE=1, EOL=1, data 16'hBEEF; sink asserts i_tx_busy for 3 cycles after each acceptance -> "BEEF\n" (42 45 45 46 0A); o_tx_data stable throughout each stall.
- Second i_stb (32'hFFFFFFFF) issued mid-word -> ignored; the original word completes unchanged, then a third i_stb at the o_done cycle is accepted and its first byte strobes 1 cycle later.
- i_reset_n pulled low after the 5th byte is accepted -> o_tx_stb and o_busy go 0 asynchronously, with no o_done; after release, a new word 32'h0 prints "0x00000000\r\n" in full.
- TXHEX_ZERO_SUPPRESS_EN defined, defaults: 32'h000000A0 -> "0xa0\r\n"; 32'h0 -> "0x0\r\n"; 32'h80000000 -> all 8 digits sent.
- DW=4, PREFIX=0, EOL=0, data 4'h7 -> single byte 37; o_busy high exactly one accepted byte, o_done the next cycle.

Source files
------------

// File: rtl/txhex_word.sv
// txhex_word: prints a DW-bit word as ASCII hex bytes (optional "0x", terminator) over a strobe/busy byte link.
// Build option: define TXHEX_ZERO_SUPPRESS_EN to drop leading zero digits.
module txhex_word #(
    parameter int unsigned DW        = 32,
    parameter int unsigned PREFIX    = 1,
    parameter int unsigned UPPERCASE = 0,
    parameter int unsigned EOL       = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_stb,
    input  logic [DW-1:0] i_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_tx_stb,
    output logic [7:0]    o_tx_data,
    input  logic          i_tx_busy
);
    localparam int unsigned NIB = DW / 4;
    localparam int unsigned CW  = $clog2(NIB + 1);

    if ((DW % 4) != 0 || DW < 4 || DW > 64) begin : g_bad_dw
        $error("txhex_word: DW must be a multiple of 4 in the range 4..64");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PFX0,
        S_PFX1,
        S_DIGIT,
        S_CR,
        S_LF
    } state_t;

    state_t        state;
    logic [DW-1:0] sr;
    logic [CW-1:0] cnt;
    logic [DW-1:0] sr_shl;
    logic [DW-1:0] cap_sr;
    logic [CW-1:0] cap_cnt;
    logic          tx_accept;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return (UPPERCASE != 0) ? 8'h37 + 8'(n) : 8'h57 + 8'(n);
    endfunction

`ifdef TXHEX_ZERO_SUPPRESS_EN
    // Leading zero nibbles, capped so the least significant digit is always sent.
    function automatic logic [CW-1:0] lead_zeros(input logic [DW-1:0] d);
        logic [CW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = int'(NIB) - 1; i >= 1; i--) begin
            if (d[i*4 +: 4] != 4'h0) found = 1'b1;
            else if (!found) n = n + CW'(1);
        end
        return n;
    endfunction

    logic [CW-1:0] cap_lz;
    assign cap_lz  = lead_zeros(i_data);
    assign cap_sr  = i_data << {cap_lz, 2'b00};
    assign cap_cnt = CW'(NIB) - cap_lz;
`else
    assign cap_sr  = i_data;
    assign cap_cnt = CW'(NIB);
`endif

    assign sr_shl    = sr << 4;
    assign tx_accept = o_tx_stb && !i_tx_busy;

    // Sequencer: each state owns one character; advance only when the sink takes it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_IDLE;
            sr        <= '0;
            cnt       <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_tx_stb  <= 1'b0;
            o_tx_data <= 8'h00;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_stb && !o_busy) begin
                        sr       <= cap_sr;
                        cnt      <= cap_cnt;
                        o_busy   <= 1'b1;
                        o_tx_stb <= 1'b1;
                        if (PREFIX != 0) begin
                            state     <= S_PFX0;
                            o_tx_data <= 8'h30;
                        end else begin
                            state     <= S_DIGIT;
                            o_tx_data <= hex_char(cap_sr[DW-1 -: 4]);
                        end
                    end
                end
                S_PFX0: begin
                    if (tx_accept) begin
                        state     <= S_PFX1;
                        o_tx_data <= 8'h78;
                    end
                end
                S_PFX1: begin
                    if (tx_accept) begin
                        state     <= S_DIGIT;
                        o_tx_data <= hex_char(sr[DW-1 -: 4]);
                    end
                end
                S_DIGIT: begin
                    if (tx_accept) begin
                        sr <= sr_shl;
                        if (cnt > CW'(1)) begin
                            cnt       <= cnt - CW'(1);
                            o_tx_data <= hex_char(sr_shl[DW-1 -: 4]);
                        end else begin
                            cnt <= '0;
                            if (EOL >= 2) begin
                                state     <= S_CR;
                                o_tx_data <= 8'h0D;
                            end else if (EOL == 1) begin
                                state     <= S_LF;
                                o_tx_data <= 8'h0A;
                            end else begin
                                state    <= S_IDLE;
                                o_busy   <= 1'b0;
                                o_tx_stb <= 1'b0;
                                o_done   <= 1'b1;
                            end
                        end
                    end
                end
                S_CR: begin
                    if (tx_accept) begin
                        state     <= S_LF;
                        o_tx_data <= 8'h0A;
                    end
                end
                S_LF: begin
                    if (tx_accept) begin
                        state    <= S_IDLE;
                        o_busy   <= 1'b0;
                        o_tx_stb <= 1'b0;
                        o_done   <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    o_busy   <= 1'b0;
                    o_tx_stb <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_txhex_word.sv
// tb_txhex_word: directed checks of txhex_word in three configurations sharing one clock and reset.
module tb_txhex_word;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb;
    logic [31:0] din;
    logic        tx_busy;
    int          sel;

    logic        d0_busy, d0_done, d0_stb;
    logic [7:0]  d0_data;
    logic        d1_busy, d1_done, d1_stb;
    logic [7:0]  d1_data;
    logic        d2_busy, d2_done, d2_stb;
    logic [7:0]  d2_data;

    logic        obs_busy, obs_done, obs_stb;
    logic [7:0]  obs_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    txhex_word u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb && sel == 0), .i_data(din),
        .o_busy(d0_busy), .o_done(d0_done), .o_tx_stb(d0_stb), .o_tx_data(d0_data),
        .i_tx_busy(tx_busy)
    );

    txhex_word #(.DW(16), .PREFIX(0), .UPPERCASE(1), .EOL(1)) u_b16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb && sel == 1), .i_data(din[15:0]),
        .o_busy(d1_busy), .o_done(d1_done), .o_tx_stb(d1_stb), .o_tx_data(d1_data),
        .i_tx_busy(tx_busy)
    );

    txhex_word #(.DW(4), .PREFIX(0), .EOL(0)) u_b4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb && sel == 2), .i_data(din[3:0]),
        .o_busy(d2_busy), .o_done(d2_done), .o_tx_stb(d2_stb), .o_tx_data(d2_data),
        .i_tx_busy(tx_busy)
    );

    always_comb begin
        obs_busy = d0_busy;
        obs_done = d0_done;
        obs_stb  = d0_stb;
        obs_data = d0_data;
        if (sel == 1) begin
            obs_busy = d1_busy;
            obs_done = d1_done;
            obs_stb  = d1_stb;
            obs_data = d1_data;
        end else if (sel == 2) begin
            obs_busy = d2_busy;
            obs_done = d2_done;
            obs_stb  = d2_stb;
            obs_data = d2_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    // Issue one word at the current negedge and follow it byte by byte.
    // stall: sink-busy cycles per byte; poke_at: byte index at which a stray request is sent;
    // abort_at: byte index at which reset is pulled instead of continuing.
    task automatic send_word(input logic [31:0] data, input string exp, input int stall,
                             input int poke_at, input int abort_at);
        int   n;
        logic seen;
        n       = exp.len();
        tx_busy = 1'b0;
        din     = data;
        stb     = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        check("start", {obs_busy, obs_done}, 2'b10);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_async", {obs_busy, obs_stb, obs_done, obs_data}, 64'h0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                seen  = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    seen = seen | obs_busy | obs_stb | obs_done;
                end
                check("abort_quiet", seen, 1'b0);
                return;
            end
            check($sformatf("byte%0d", i), {obs_stb, obs_data}, {1'b1, 8'(exp[i])});
            if (i == poke_at) begin
                din = 32'hFFFF_FFFF;
                stb = 1'b1;
            end
            if (stall > 0) begin
                tx_busy = 1'b1;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    stb = 1'b0;
                    check($sformatf("stall%0d", i), {obs_stb, obs_data}, {1'b1, 8'(exp[i])});
                end
                tx_busy = 1'b0;
            end
            @(negedge clk);
            stb = 1'b0;
        end
        check("done", {obs_busy, obs_stb, obs_done, obs_data}, {3'b001, 8'(exp[n-1])});
    endtask

    initial begin
        rst_n   = 1'b0;
        sel     = 0;
        stb     = 1'b0;
        din     = '0;
        tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", {obs_busy, obs_done, obs_stb, obs_data}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        send_word(32'h1234_5678, "0x12345678\r\n", 0, -1, -1);
        @(negedge clk);
        check("done_1cyc", obs_done, 1'b0);

        // Stray request mid-word, then a new request on the done cycle.
        send_word(32'hCAFE_0123, "0xcafe0123\r\n", 1, 3, -1);
        send_word(32'h9ABC_DEF0, "0x9abcdef0\r\n", 0, -1, -1);
        @(negedge clk);

        send_word(32'h1234_5678, "0x12345678\r\n", 0, -1, 5);
`ifdef TXHEX_ZERO_SUPPRESS_EN
        send_word(32'h0, "0x0\r\n", 0, -1, -1);
        send_word(32'h0000_00A0, "0xa0\r\n", 0, -1, -1);
`else
        send_word(32'h0, "0x00000000\r\n", 0, -1, -1);
        send_word(32'h0000_00A0, "0x000000a0\r\n", 0, -1, -1);
`endif
        send_word(32'h8000_0000, "0x80000000\r\n", 0, -1, -1);
        @(negedge clk);

        sel = 1;
        send_word(32'h0000_BEEF, "BEEF\n", 3, -1, -1);
        @(negedge clk);
`ifdef TXHEX_ZERO_SUPPRESS_EN
        send_word(32'h0000_00A5, "A5\n", 0, -1, -1);
`else
        send_word(32'h0000_00A5, "00A5\n", 0, -1, -1);
`endif
        @(negedge clk);

        sel = 2;
        send_word(32'h7, "7", 0, -1, -1);
        @(negedge clk);
        check("b4_idle", {obs_busy, obs_done}, 2'b00);
        send_word(32'hC, "c", 2, -1, -1);
        send_word(32'h0, "0", 0, -1, -1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
